// File: rtl/general_round.sv
// One AES-128 middle round, encrypt or decrypt, with a registered output.
// Both directions are evaluated in parallel and encrypt picks the one that is captured.
module general_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         encrypt,
    input  logic [127:0] keyword,
    input  logic [127:0] input_data,
    input  logic         in_valid,
    output logic [127:0] result,
    output logic         out_valid
);

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
            8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
            8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
            8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
            8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
            8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
            8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
            8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
            8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
            8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
            8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
            8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
            8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
            8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
            8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
            8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
            8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
            8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
            8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
            8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
            8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
            8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
            8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
            8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
            8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
            8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
            8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
            8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
            8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
            8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
            8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
            8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
        endcase
        return s;
    endfunction

    // Multiply by {02} modulo x^8 + x^4 + x^3 + x + 1; the other constants are xor-sums of its powers.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(v[127-8*i -: 8]) : sbox(v[127-8*i -: 8]);
        return o;
    endfunction

    // Byte r+4c is row r, column c; forward rotates rows left, inverse rotates right.
    function automatic logic [127:0] shift_rows(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv ? v[127-8*(4*((c+4-r)%4)+r) -: 8]
                                            : v[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = inv ? inv_mix_col(v[127-32*c -: 32]) : mix_col(v[127-32*c -: 32]);
        return o;
    endfunction

    logic [127:0] enc_state;
    logic [127:0] dec_state;

    assign enc_state = mix_columns(shift_rows(sub_bytes(input_data, 1'b0), 1'b0), 1'b0) ^ keyword;
    assign dec_state = sub_bytes(shift_rows(mix_columns(input_data ^ keyword, 1'b1), 1'b1), 1'b1);

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                result <= encrypt ? enc_state : dec_state;
        end
    end

endmodule

// File: tb/tb_general_round.sv
// Bench for general_round: FIPS-197 known answers, hold/reset sequences and
// random rounds against a field-arithmetic model of the AES round.
module tb_general_round;

    logic         clk = 1'b0;
    logic         rst;
    logic         encrypt;
    logic [127:0] keyword;
    logic [127:0] input_data;
    logic         in_valid;
    logic [127:0] result;
    logic         out_valid;

    int errors = 0;
    int checks = 0;

    general_round dut (
        .clk       (clk),
        .rst       (rst),
        .encrypt   (encrypt),
        .keyword   (keyword),
        .input_data(input_data),
        .in_valid  (in_valid),
        .result    (result),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         enc;
        logic [127:0] key;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            logic [7:0] s;
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_round(input logic enc, input logic [127:0] key,
                                                 input logic [127:0] din);
        logic [7:0] st [16];
        logic [7:0] tmp[16];
        logic [7:0] m  [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) st[i] = din[127-8*i -: 8];
        if (enc) begin
            m = '{8'h02, 8'h03, 8'h01, 8'h01};
            for (int i = 0; i < 16; i++) tmp[i] = sbox_t[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*((c+r)%4)];
        end else begin
            m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ key[127-8*i -: 8];
        end
        // Circulant matrix product: out[r] = sum_j m[(j - r) mod 4] * col[j].
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                tmp[4*c+r] = 8'h00;
                for (int j = 0; j < 4; j++)
                    tmp[4*c+r] = tmp[4*c+r] ^ gmul(m[(j-r+4)%4], st[4*c+j]);
            end
        if (enc) begin
            for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ key[127-8*i -: 8];
        end else begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r+4*c] = isbox_t[tmp[r+4*((c-r+4)%4)]];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic enc, input logic [127:0] key,
                         input logic [127:0] din);
        in_valid   = iv;
        encrypt    = enc;
        keyword    = key;
        input_data = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] K1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2 = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    localparam logic [127:0] K3 = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    localparam logic [127:0] S0 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] S1 = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] S2 = 128'h4915598f55e5d7a0daca94fa1f0a63f7;
    localparam logic [127:0] S3 = 128'hfa636a2825b339c940668a3157244d17;

    initial begin
        logic [127:0] exp_res;
        logic         exp_ov;

        vecs[0] = '{1'b1, K1, S0, S1};
        vecs[1] = '{1'b1, K2, S1, S2};
        vecs[2] = '{1'b1, K3, S2, S3};
        vecs[3] = '{1'b0, K1, S1, S0};
        vecs[4] = '{1'b0, K2, S2, S1};
        vecs[5] = '{1'b0, K3, S3, S2};

        build_tables();

        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("reset_result", result, '0);
        check("reset_valid", out_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("post_reset_result", result, '0);
        check("post_reset_valid", out_valid, 1'b0);

        // Known-answer vectors, applied back-to-back with no bubbles.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].enc, vecs[i].key, vecs[i].din);
            tick();
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
        end

        // Hold when in_valid drops, then a decrypt round.
        drive(1'b1, 1'b1, K1, S0);
        tick();
        check("hold_load", result, S1);
        drive(1'b0, 1'b0, K3, S3);
        tick();
        check("hold_result", result, S1);
        check("hold_valid", out_valid, 1'b0);
        tick();
        check("hold_result2", result, S1);
        drive(1'b1, 1'b0, K2, S2);
        tick();
        check("mixed_dec_result", result, S1);
        check("mixed_dec_valid", out_valid, 1'b1);

        // Reset in the cycle after a valid input; in_valid is ignored while rst is high.
        drive(1'b1, 1'b1, K1, S0);
        tick();
        check("pre_rst_load", result, S1);
        drive(1'b1, 1'b1, K2, S1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_result", result, '0);
        check("mid_rst_valid", out_valid, 1'b0);
        tick();
        check("rst_held_result", result, '0);
        check("rst_held_valid", out_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("post_rst_load", result, S2);
        check("post_rst_valid", out_valid, 1'b1);

        // Random rounds, random direction and random gaps.
        exp_res = S2;
        for (int n = 0; n < 400; n++) begin
            logic         iv;
            logic         enc;
            logic [127:0] key;
            logic [127:0] din;
            iv  = ($urandom_range(0, 3) != 0);
            enc = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom, $urandom, $urandom};
            din = {$urandom, $urandom, $urandom, $urandom};
            drive(iv, enc, key, din);
            if (iv) exp_res = model_round(enc, key, din);
            exp_ov = iv;
            tick();
            check($sformatf("rand%0d_result", n), result, exp_res);
            check($sformatf("rand%0d_valid", n), out_valid, exp_ov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
